sram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the 8x16 1R1W sky130 SRAM macro as FIFO storage.
- Drives the macro's write port (csb0/addr0/din0) and read port (csb1/addr1), and captures dout1 into a 2-entry output buffer.
- Presents valid/ready streams on both sides.
- Both macro clocks (clk0, clk1) are tied to clk at the parent level.

---
 rtl/sram_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller sequencing an 8x16 1R1W SRAM macro; optional write bypass under SRAM_FIFO_CTRL_BYPASS_EN.
// Latency: write to out_valid is 2 cycles through the SRAM, 1 cycle when a write is bypassed.
// Backpressure: in_ready falls while the SRAM holds RAM_DEPTH entries; reads stall when the 2-entry output buffer would overflow.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(RAM_DEPTH);

    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

    logic [PW-1:0]         sram_cnt;
    logic                  push_acc, pop, byp, wr_en, rd_issue, ret;
    logic [2:0]            occ;
    logic [1:0]            cnt_after_pop;
    logic [DATA_WIDTH-1:0] ret_dat;

    always_comb begin
        sram_cnt  = wptr_q - rptr_q;
        in_ready  = rst_n && !flush && (sram_cnt < DEPTH_P);
        out_valid = (buf_cnt_q != 2'd0);
        out_data  = buf0_q;
        pop       = out_valid && out_ready;
        push_acc  = in_valid && in_ready;
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
        // Only when nothing older sits in the SRAM or the read pipe, so order holds.
        byp = push_acc && (sram_cnt == '0) && !rd_inflight_q && (buf_cnt_q != 2'd2);
`else
        byp = 1'b0;
`endif
        wr_en = push_acc && !byp;

        // Buffer slots committed after this cycle's pop; a new read may claim one.
        occ      = {1'b0, buf_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
        rd_issue = rst_n && !flush && (sram_cnt != '0) && (occ < 3'd2);
        ret      = rd_inflight_q && !flush;

        sram_csb0  = !wr_en;
        sram_addr0 = wr_en ? wptr_q[ADDR_WIDTH-1:0] : '0;
        sram_din0  = wr_en ? in_data : '0;
        sram_csb1  = !rd_issue;
        sram_addr1 = rd_issue ? rptr_q[ADDR_WIDTH-1:0] : '0;
        count      = sram_cnt + PW'(buf_cnt_q) + PW'(rd_inflight_q);

        wptr_d        = wptr_q + PW'(wr_en);
        rptr_d        = flush ? wptr_q : rptr_q + PW'(rd_issue);
        rd_inflight_d = rd_issue;

        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        cnt_after_pop = buf_cnt_q - {1'b0, pop};
        ret_dat       = ret ? sram_dout1 : in_data;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (ret || byp) begin
            if (cnt_after_pop == 2'd0) begin
                buf0_d = ret_dat;
            end else begin
                buf1_d = ret_dat;
            end
        end
        buf_cnt_d = flush ? 2'd0 : cnt_after_pop + {1'b0, (ret || byp)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            rd_inflight_q <= 1'b0;
            buf_cnt_q     <= 2'd0;
            buf0_q        <= '0;
            buf1_q        <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            rd_inflight_q <= rd_inflight_d;
            buf_cnt_q     <= buf_cnt_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural SRAM macro and a queue-based reference.
module tb_sram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       sram_csb0;
    logic [3:0] sram_addr0;
    logic [7:0] sram_din0;
    logic       sram_csb1;
    logic [3:0] sram_addr1;
    logic [7:0] sram_dout1;

    sram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    always #5 clk = ~clk;

    // Macro model: synchronous write, read data registered at the capturing edge.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  q [$];
    int unsigned wr_cnt, rd_cnt;
    logic        s_in_ready, s_csb0, s_csb1, last_acc, last_pop;
    logic [3:0]  s_addr0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample mid-cycle, advance the model at the edge, check count after it.
    task automatic cyc();
        logic acc, pop, do_wr, do_rd;
        @(negedge clk);
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        s_in_ready = in_ready; s_csb0 = sram_csb0; s_csb1 = sram_csb1; s_addr0 = sram_addr0;
        if (flush) begin
            chk("flush_in_ready", 32'(in_ready), 32'd0);
            chk("flush_csb0", 32'(sram_csb0), 32'd1);
            chk("flush_csb1", 32'(sram_csb1), 32'd1);
        end else if (q.size() <= 15) begin
            chk("in_ready_open", 32'(in_ready), 32'd1);
        end
        if (q.size() == 18) chk("in_ready_full", 32'(in_ready), 32'd0);
        if (q.size() == 0)  chk("empty_out_valid", 32'(out_valid), 32'd0);
        else if (pop)       chk("pop_data", 32'(out_data), 32'(q[0]));
        if (!sram_csb0) begin
            chk("wr_only_on_accept", 32'(acc), 32'd1);
            chk("wr_addr", 32'(sram_addr0), wr_cnt % 16);
            chk("wr_data", 32'(sram_din0), 32'(in_data));
        end
`ifndef SRAM_FIFO_CTRL_BYPASS_EN
        else if (acc) chk("wr_on_accept", 32'(sram_csb0), 32'd0);
`endif
        if (!sram_csb1) begin
            chk("rd_nonempty", 32'(wr_cnt != rd_cnt), 32'd1);
            chk("rd_addr", 32'(sram_addr1), rd_cnt % 16);
            if (!sram_csb0) chk("rd_wr_addr_differ", 32'(sram_addr0 != sram_addr1), 32'd1);
        end
        do_wr = !sram_csb0;
        do_rd = !sram_csb1;
        @(posedge clk);
        if (flush) begin
            q.delete();
            rd_cnt = wr_cnt;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(in_data);
            if (do_wr) wr_cnt++;
            if (do_rd) rd_cnt++;
        end
        last_acc = acc;
        last_pop = pop;
        #1;
        chk("count", 32'(count), 32'(q.size()));
    endtask

    initial begin
        int n, gaps;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
        wr_cnt = 0; rd_cnt = 0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_csb0", 32'(sram_csb0), 32'd1);
        chk("rst_csb1", 32'(sram_csb1), 32'd1);
        chk("rst_addr0", 32'(sram_addr0), 32'd0);
        chk("rst_addr1", 32'(sram_addr1), 32'd0);
        chk("rst_din0", 32'(sram_din0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;

        // First-write latency
        in_valid = 1'b1; in_data = 8'hA5;
        cyc();
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
        chk("lat_bypass_csb0", 32'(s_csb0), 32'd1);
`else
        chk("lat_csb0", 32'(s_csb0), 32'd0);
        chk("lat_addr0", 32'(s_addr0), 32'd0);
`endif
        in_valid = 1'b0;
        cyc();
`ifdef SRAM_FIFO_CTRL_BYPASS_EN
        chk("lat_t1_valid", 32'(out_valid), 32'd1);
`else
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
`endif
        cyc();
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("lat_t2_data", 32'(out_data), 32'hA5);
        chk("lat_t2_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        cyc(); cyc();
        out_ready = 1'b0;

        // Fill to capacity with the consumer stalled
        n = 0;
        for (int i = 0; i < 60 && n < 18; i++) begin
            in_valid = 1'b1; in_data = 8'(n);
            cyc();
            if (last_acc) n++;
        end
        chk("fill_accepted", 32'(n), 32'd18);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd18);
        in_data = 8'h77;
        for (int i = 0; i < 3; i++) cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("reopen_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 25; i++) cyc();
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Streaming through pointer wrap
        gaps = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'($urandom);
            cyc();
            if (i >= 3 && !last_pop) gaps++;
        end
        chk("stream_gaps", 32'(gaps), 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("stream_drained", 32'(count), 32'd0);

        // Flush
        out_ready = 1'b0; n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            cyc();
            if (last_acc) n++;
        end
        chk("flush_fill", 32'(n), 32'd10);
        flush = 1'b1; in_data = 8'hEE;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h3C;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_data", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        cyc();

        // Reset mid-stream with a read in flight
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            cyc();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_csb0", 32'(sram_csb0), 32'd1);
        chk("mid_rst_csb1", 32'(sram_csb1), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        q.delete(); wr_cnt = 0; rd_cnt = 0;
        @(posedge clk); #1;
        chk("after_rst_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i < 2); in_data = 8'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("after_rst_drained", 32'(count), 32'd0);

        // Random traffic against the reference queue
        n = 0;
        for (int i = 0; i < 3000 && n < 200; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
            if (last_acc) n++;
        end
        chk("rand_accepted", 32'(n), 32'd200);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) cyc();
        chk("rand_drained", 32'(count), 32'd0);
        chk("rand_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
